// File: rtl/systolic_ctrl.sv
// systolic_ctrl: job sequencer for the weight-stationary systolic array.
// Loads an NxN weight tile on the north edge, then streams row-skewed switch/input vectors on the west edge.
module systolic_ctrl #(
  parameter int SYSTOLIC_ARRAY_WIDTH = 16,
  parameter int DATA_WIDTH_IN        = 8
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            start,
  input  logic [15:0]                                     num_vec,
  input  logic [SYSTOLIC_ARRAY_WIDTH-1:0]                 col_en,
  output logic                                            busy,
  output logic                                            done,
  input  logic                                            wt_valid,
  output logic                                            wt_ready,
  input  logic [SYSTOLIC_ARRAY_WIDTH*DATA_WIDTH_IN-1:0]   wt_data,
  input  logic                                            in_valid,
  output logic                                            in_ready,
  input  logic [SYSTOLIC_ARRAY_WIDTH*DATA_WIDTH_IN-1:0]   in_data,
  output logic [SYSTOLIC_ARRAY_WIDTH-1:0]                 arr_enabled,
  output logic [SYSTOLIC_ARRAY_WIDTH*DATA_WIDTH_IN-1:0]   arr_weight,
  output logic [$clog2(SYSTOLIC_ARRAY_WIDTH)-1:0]         arr_index,
  output logic [SYSTOLIC_ARRAY_WIDTH-1:0]                 arr_accept_w,
  output logic [SYSTOLIC_ARRAY_WIDTH*DATA_WIDTH_IN-1:0]   arr_input,
  output logic [SYSTOLIC_ARRAY_WIDTH-1:0]                 arr_valid,
  output logic [SYSTOLIC_ARRAY_WIDTH-1:0]                 arr_switch
);

  localparam int N  = SYSTOLIC_ARRAY_WIDTH;
  localparam int DW = DATA_WIDTH_IN;
  localparam int IW = $clog2(N);
  localparam int TW = $clog2(N) + 1;

  localparam logic [IW-1:0] K_LAST       = IW'(N - 1);
  localparam logic [TW-1:0] T_DRAIN_LAST = TW'(N - 1);
  localparam logic [TW-1:0] T_FLUSH_LAST = TW'(2 * N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_SWITCH,
    S_COMPUTE,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [15:0]         r_m;
  logic [15:0]         r_vcnt;
  logic [N-1:0]        r_en;
  logic [IW-1:0]       r_kcnt;
  logic [TW-1:0]       r_tcnt;

  logic                w_wt_fire;
  logic                w_in_fire;
  logic                w_s0_switch;
  logic                w_s0_valid;
  logic [N*DW-1:0]     w_s0_data;

  logic [N*DW-1:0]     r_arr_weight;
  logic [IW-1:0]       r_arr_index;
  logic [N-1:0]        r_arr_accept_w;

  assign w_wt_fire = (r_state == S_LOAD) && wt_valid;
  assign w_in_fire = (r_state == S_COMPUTE) && in_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_s0_switch = 1'b0;
    w_s0_valid  = 1'b0;
    w_s0_data   = '0;
    case (r_state)
      S_IDLE:    if (start) w_next = S_LOAD;
      S_LOAD:    if (w_wt_fire && (r_kcnt == K_LAST)) w_next = S_DRAIN;
      S_DRAIN:   if (r_tcnt == T_DRAIN_LAST) w_next = S_SWITCH;
      S_SWITCH: begin
        w_s0_switch = 1'b1;
        w_next      = (r_m == 16'd0) ? S_FLUSH : S_COMPUTE;
      end
      S_COMPUTE: begin
        if (w_in_fire) begin
          w_s0_valid = 1'b1;
          w_s0_data  = in_data;
          if (r_vcnt == (r_m - 16'd1)) w_next = S_FLUSH;
        end
      end
      S_FLUSH:   if (r_tcnt == T_FLUSH_LAST) w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_m    <= '0;
      r_en   <= '0;
      r_kcnt <= '0;
      r_tcnt <= '0;
      r_vcnt <= '0;
    end else begin
      if ((r_state == S_IDLE) && start) begin
        r_m    <= num_vec;
        r_en   <= col_en;
        r_kcnt <= '0;
      end else if (w_wt_fire) begin
        r_kcnt <= r_kcnt + 1'b1;
      end

      if (r_state != w_next)
        r_tcnt <= '0;
      else if ((r_state == S_DRAIN) || (r_state == S_FLUSH))
        r_tcnt <= r_tcnt + 1'b1;

      if (r_state == S_SWITCH)
        r_vcnt <= '0;
      else if (w_in_fire)
        r_vcnt <= r_vcnt + 16'd1;
    end
  end

  // North edge: one registered stage, zeroed on every cycle without an accepted beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_arr_weight   <= '0;
      r_arr_index    <= '0;
      r_arr_accept_w <= '0;
    end else if (w_wt_fire) begin
      r_arr_weight   <= wt_data;
      r_arr_index    <= r_kcnt;
      r_arr_accept_w <= r_en;
    end else begin
      r_arr_weight   <= '0;
      r_arr_index    <= '0;
      r_arr_accept_w <= '0;
    end
  end

  assign arr_weight   = r_arr_weight;
  assign arr_index    = r_arr_index;
  assign arr_accept_w = r_arr_accept_w;

  // Triangular skew: row r carries only its own lane through r+1 stages of {switch, valid, data}.
  for (genvar r = 0; r < N; r++) begin : g_skew
    localparam int unsigned ROW = r;
    logic [DW+1:0] r_sk [0:ROW];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int unsigned i = 0; i <= ROW; i++) r_sk[i] <= '0;
      end else begin
        r_sk[0] <= {w_s0_switch, w_s0_valid, w_s0_data[r*DW +: DW]};
        for (int unsigned i = 1; i <= ROW; i++) r_sk[i] <= r_sk[i-1];
      end
    end

    assign arr_switch[r]           = r_sk[ROW][DW+1];
    assign arr_valid[r]            = r_sk[ROW][DW];
    assign arr_input[r*DW +: DW]   = r_sk[ROW][DW-1:0];
  end

  assign busy        = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done        = (r_state == S_DONE);
  assign wt_ready    = (r_state == S_LOAD);
  assign in_ready    = (r_state == S_COMPUTE);
  assign arr_enabled = (r_state == S_IDLE) ? '0 : r_en;

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl (N=4, int8): checks handshakes, phase timing and
// north/west edge contents cycle by cycle against hand-derived schedules.
module tb_systolic_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] num_vec;
  logic [3:0]  col_en;
  logic        busy;
  logic        done;
  logic        wt_valid;
  logic        wt_ready;
  logic [31:0] wt_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [3:0]  arr_enabled;
  logic [31:0] arr_weight;
  logic [1:0]  arr_index;
  logic [3:0]  arr_accept_w;
  logic [31:0] arr_input;
  logic [3:0]  arr_valid;
  logic [3:0]  arr_switch;

  int n_cmp;
  int n_err;

  logic [31:0] wtab [0:3];
  logic [31:0] vtab [0:7];

  systolic_ctrl #(
    .SYSTOLIC_ARRAY_WIDTH(4),
    .DATA_WIDTH_IN(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .num_vec(num_vec),
    .col_en(col_en),
    .busy(busy),
    .done(done),
    .wt_valid(wt_valid),
    .wt_ready(wt_ready),
    .wt_data(wt_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .arr_enabled(arr_enabled),
    .arr_weight(arr_weight),
    .arr_index(arr_index),
    .arr_accept_w(arr_accept_w),
    .arr_input(arr_input),
    .arr_valid(arr_valid),
    .arr_switch(arr_switch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int cyc, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s @%0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag, input int cyc);
    chk({tag, "_ctl"}, cyc,
        64'({busy, done, wt_ready, in_ready, arr_enabled, arr_index, arr_accept_w, arr_valid, arr_switch}),
        64'd0);
    chk({tag, "_wt"}, cyc, 64'(arr_weight), 64'd0);
    chk({tag, "_in"}, cyc, 64'(arr_input), 64'd0);
  endtask

  // One job. Cycle i=0 is the IDLE cycle presenting start. Hand-derived schedule:
  // lw = last LOAD cycle, s = SWITCH cycle, lv = last COMPUTE cycle (lv==s if M=0),
  // done_c = DONE cycle. wv/iv mark cycles with wt_valid/in_valid, stm marks start pulses.
  task automatic run_job(input int m, input logic [3:0] en, input logic [63:0] wv, input int lw,
                         input int s, input logic [63:0] iv, input int lv, input int done_c,
                         input logic [63:0] stm);
    int          bk [0:63];
    int          vi [0:63];
    int          nb;
    int          nv;
    logic [37:0] exp_n;
    logic [3:0]  ev;
    logic [3:0]  es;
    logic [31:0] ed;
    nb = 0;
    nv = 0;
    for (int c = 0; c < 64; c++) begin
      bk[c] = nb;
      vi[c] = nv;
      if (wv[c]) nb++;
      if (iv[c]) nv++;
    end
    for (int i = 0; i <= done_c + 1; i++) begin
      @(negedge clk);
      chk("busy",     i, 64'(busy),     64'(i >= 1 && i < done_c));
      chk("done",     i, 64'(done),     64'(i == done_c));
      chk("wt_ready", i, 64'(wt_ready), 64'(i >= 1 && i <= lw));
      chk("in_ready", i, 64'(in_ready), 64'(i > s && i <= lv));
      if (i >= 1 && i < done_c)
        chk("arr_enabled", i, 64'(arr_enabled), 64'(en));
      else if (i == 0 || i == done_c + 1)
        chk("arr_enabled", i, 64'(arr_enabled), 64'd0);

      exp_n = '0;
      if (i >= 1 && wv[i-1]) exp_n = {en, 2'(bk[i-1]), wtab[bk[i-1]]};
      chk("north", i, 64'({arr_accept_w, arr_index, arr_weight}), 64'(exp_n));

      ev = '0;
      es = '0;
      ed = '0;
      for (int r = 0; r < 4; r++) begin
        int c;
        c = i - 1 - r;
        es[r] = (i == s + 1 + r);
        if (c >= 0 && iv[c]) begin
          ev[r] = 1'b1;
          ed[r*8 +: 8] = vtab[vi[c]][r*8 +: 8];
        end
      end
      chk("west_valid",  i, 64'(arr_valid),  64'(ev));
      chk("west_switch", i, 64'(arr_switch), 64'(es));
      chk("west_data",   i, 64'(arr_input),  64'(ed));

      start    = stm[i];
      num_vec  = (i == 0) ? 16'(m) : 16'hFFFF;
      col_en   = (i == 0) ? en : ~en;
      wt_valid = wv[i];
      wt_data  = wv[i] ? wtab[bk[i]] : 32'hDEADBEEF;
      in_valid = iv[i];
      in_data  = iv[i] ? vtab[vi[i]] : 32'h5A5A5A5A;
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst      = 1'b0;
    start    = 1'b0;
    num_vec  = '0;
    col_en   = '0;
    wt_valid = 1'b0;
    wt_data  = '0;
    in_valid = 1'b0;
    in_data  = '0;
    wtab[0] = 32'h00000001; wtab[1] = 32'h00000100;
    wtab[2] = 32'h00010000; wtab[3] = 32'h01000000;
    vtab[0] = 32'h04030201; vtab[1] = 32'h08070605; vtab[2] = 32'hFCFDFEFF;
    vtab[3] = '0; vtab[4] = '0; vtab[5] = '0; vtab[6] = '0; vtab[7] = '0;

    repeat (3) @(negedge clk);
    chk_all_zero("reset", 0);
    rst = 1'b1;

    // Reset in the middle of LOAD, after two accepted beats.
    @(negedge clk);
    start = 1'b1; num_vec = 16'd3; col_en = 4'hF;
    @(negedge clk);
    start = 1'b0;
    chk("midload_busy", 1, 64'(busy), 64'd1);
    wt_valid = 1'b1; wt_data = wtab[0];
    @(negedge clk);
    wt_data = wtab[1];
    @(negedge clk);
    chk("midload_north", 3, 64'({arr_accept_w, arr_index}), 64'({4'hF, 2'd1}));
    wt_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk_all_zero("async_rst", 3);
    repeat (2) begin
      @(negedge clk);
      chk("rst_no_done", 4, 64'({busy, done}), 64'd0);
    end
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_idle", 6, 64'({busy, wt_ready, arr_enabled}), 64'd0);
    end

    // Identity tile, M=3, no stalls.
    run_job(3, 4'hF, 64'h1E, 4, 9, 64'h1C00, 12, 21, 64'h1);

    // Stalled streams, col_en=0101, M=3.
    wtab[0] = 32'h7F8001FF; wtab[1] = 32'h12345678;
    wtab[2] = 32'h9ABCDEF0; wtab[3] = 32'h0F1E2D3C;
    vtab[0] = 32'h11223344; vtab[1] = 32'h80FF7F01; vtab[2] = 32'hCAFEBABE;
    run_job(3, 4'b0101, 64'h5A, 6, 11, 64'hD000, 15, 24, 64'h1);

    // M=0: switch only, DONE at s+2N+1.
    run_job(0, 4'hF, 64'h1E, 4, 9, 64'h0, 9, 18, 64'h1);

    // Starts during COMPUTE (11) and in DONE (21) are ignored; next start 2 cycles after done.
    wtab[0] = 32'h00000001; wtab[1] = 32'h00000100;
    wtab[2] = 32'h00010000; wtab[3] = 32'h01000000;
    vtab[0] = 32'h04030201; vtab[1] = 32'h08070605; vtab[2] = 32'hFCFDFEFF;
    run_job(3, 4'hF, 64'h1E, 4, 9, 64'h1C00, 12, 21, 64'h200801);
    run_job(1, 4'b1100, 64'h1E, 4, 9, 64'h1000, 12, 21, 64'h1);

    // Gapped streams, M=8, col_en=1011.
    wtab[0] = 32'h80018002; wtab[1] = 32'h7F7E7D7C;
    wtab[2] = 32'hF00DFACE; wtab[3] = 32'h01020304;
    for (int k = 0; k < 8; k++) vtab[k] = {8'(k * 17 + 1), 8'(8'hF0 - k), 8'(k * 3), 8'(8'h80 + k)};
    run_job(8, 4'b1011, 64'h96, 7, 12, 64'h25DA000, 25, 34, 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
